// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, buffers fetched words for decode,
// and shares the combinational imem read port with a debug/loader requester.
module imem_fetch_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int INST_W    = 32,
   parameter int DEPTH     = 4,
   parameter int RESET_PC  = 0,
   parameter int DBG_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_instruction,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_instruction,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_grant,
   output logic [INST_W-1:0] dbg_rdata
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(DBG_BURST + 1);
   localparam logic [CW-1:0]     FULL  = CW'(DEPTH);
   localparam logic [SW-1:0]     BURST = SW'(DBG_BURST);
   localparam logic [ADDR_W-1:0] PC0   = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count;
   logic [SW-1:0]     dbg_streak;

   logic pop, push, fetch_want;

   // Decode handshake: a word transfers when out_valid & out_ready are both high on
   // a rising edge; out_valid never depends on out_ready, and a redirect or reset
   // masks out_valid so nothing is consumed in a flushing cycle.
   always_comb begin
      out_valid  = ~reset & (count != '0) & ~redirect_valid;
      pop        = out_valid & out_ready;
      fetch_want = ~reset & ~redirect_valid & ((count < FULL) | pop);
      dbg_grant  = ~reset & dbg_req & ~(fetch_want & (dbg_streak == BURST));
      push       = fetch_want & ~dbg_grant;
      imem_addr  = dbg_grant ? dbg_addr : fetch_pc;
   end

   assign out_pc          = pc_mem[rd_ptr];
   assign out_instruction = inst_mem[rd_ptr];
   assign dbg_rdata       = imem_instruction;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc   <= PC0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         dbg_streak <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else begin
         if (redirect_valid) begin
            fetch_pc <= redirect_pc & ALIGN;
            rd_ptr   <= wr_ptr;
            count    <= '0;
         end else begin
            if (push) begin
               pc_mem[wr_ptr]   <= fetch_pc;
               inst_mem[wr_ptr] <= imem_instruction;
               wr_ptr           <= wr_ptr + PW'(1);
               fetch_pc         <= fetch_pc + STEP;
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            if (push & ~pop)
               count <= count + CW'(1);
            else if (pop & ~push)
               count <= count - CW'(1);
         end
         // Streak counts grants that kept a waiting fetch off the port.
         if (push | ~dbg_req)
            dbg_streak <= '0;
         else if (dbg_grant & fetch_want)
            dbg_streak <= dbg_streak + SW'(1);
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, fill/drain sequence, then
// randomized traffic checked against a queue-based reference model.
module tb_imem_fetch_ctrl;

   localparam int DBG_BURST = 4;
   localparam int DEPTH     = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_instruction;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic        dbg_req = 1'b0;
   logic [31:0] dbg_addr = 32'h40;
   logic        dbg_grant;
   logic [31:0] dbg_rdata;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign imem_instruction = imem_f(imem_addr);

   imem_fetch_ctrl #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(0), .DBG_BURST(DBG_BURST)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instruction(imem_instruction),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction), .out_pc(out_pc),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_grant(dbg_grant), .dbg_rdata(dbg_rdata)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: buffered PCs in order, next fetch address, debug streak.
   logic [31:0] exp_q[$];
   logic [31:0] m_pc = '0;
   int          m_streak = 0;
   bit          m_valid, m_pop, m_want, m_grant, m_push;

   task automatic model_comb();
      m_valid = !reset && exp_q.size() != 0 && !redirect_valid;
      m_pop   = m_valid && out_ready;
      m_want  = !reset && !redirect_valid && (exp_q.size() < DEPTH || m_pop);
      m_grant = !reset && dbg_req && !(m_want && m_streak == DBG_BURST);
      m_push  = m_want && !m_grant;
   endtask

   task automatic model_update();
      if (reset) begin
         exp_q.delete();
         m_pc     = 32'h0;
         m_streak = 0;
      end else begin
         if (redirect_valid) begin
            exp_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
         end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
               exp_q.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
         end
         if (m_push || !dbg_req) m_streak = 0;
         else if (m_grant && m_want) m_streak++;
      end
   endtask

   typedef struct {
      logic        rst, rdy, dreq, redir;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic        eg;
   } vec_t;

   vec_t tbl[$];

   task automatic step(input bit has_exp, input vec_t v);
      @(negedge clk);
      model_comb();
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) begin
         chk("out_pc", out_pc, exp_q[0]);
         chk("out_instruction", out_instruction, imem_f(exp_q[0]));
      end
      chk("dbg_grant", {31'b0, dbg_grant}, {31'b0, m_grant});
      if (!reset) chk("imem_addr", imem_addr, m_grant ? dbg_addr : m_pc);
      if (m_grant) chk("dbg_rdata", dbg_rdata, imem_f(dbg_addr));
      if (has_exp) begin
         chk("tbl_valid", {31'b0, out_valid}, {31'b0, v.ev});
         if (v.ev) chk("tbl_pc", out_pc, v.epc);
         chk("tbl_grant", {31'b0, dbg_grant}, {31'b0, v.eg});
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic add(input logic rst, rdy, dreq, redir, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic eg);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.dreq = dreq; v.redir = redir; v.rpc = rpc;
      v.ev = ev; v.epc = epc; v.eg = eg;
      tbl.push_back(v);
   endtask

   vec_t none;

   initial begin
      none = '{default: '0};
      // reset, then streaming fetch one per cycle
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 1, 32'(4 * i), 0);
      // redirect to a misaligned target
      add(0, 1, 0, 1, 32'h103, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 1, 32'h100, 0);
      add(0, 1, 0, 0, 0, 1, 32'h104, 0);
      // held debug request with FIFO space: 1111 0 1111 0 11
      for (int i = 0; i < 12; i++)
         add(0, 0, 1, 0, 0, 1, 32'h108, (i % 5) != 4);
      for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 1, 32'h108 + 32'(4 * i), 0);
      // reset mid-operation restarts at the reset PC
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 1, 32'h0, 0);

      #1;
      foreach (tbl[i]) begin
         reset = tbl[i].rst; out_ready = tbl[i].rdy; dbg_req = tbl[i].dreq;
         redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc; dbg_addr = 32'h40;
         step(1, tbl[i]);
      end

      // fill to full with decode stalled, then drain while fetching
      reset = 1'b1; out_ready = 1'b0; dbg_req = 1'b0; redirect_valid = 1'b0;
      step(0, none); step(0, none);
      reset = 1'b0;
      for (int i = 0; i < 7; i++) step(0, none);
      chk("full_hold_addr", imem_addr, 32'h10);
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk("stream_pc", out_pc, 32'(4 * i));
         step(0, none);
      end

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 99) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom;
         out_ready      = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) dbg_req = ~dbg_req;
         dbg_addr       = $urandom;
         step(0, none);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
